sipo_deser: RTL and testbench

//   Serial-to-parallel deserializer placed directly downstream of the SISO shift register.

---
 rtl/sipo_deser.sv | 75 +++++++
 tb/tb_sipo_deser.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-to-parallel deserializer with one-entry valid/ready holding buffer
module sipo_deser #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_in,
    input  logic                 bit_valid,
    output logic [N-1:0]         word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic [$clog2(N)-1:0] bit_count,
    output logic                 overrun,
    input  logic                 clear_ovr
);

    localparam int             CW       = $clog2(N);
    localparam logic [CW-1:0]  LAST_BIT = CW'(N - 1);
    localparam logic [0:0]     ST_EMPTY = 1'b0;
    localparam logic [0:0]     ST_FULL  = 1'b1;

    logic [0:0]   state;
    logic [N-1:0] sreg;
    logic [N-1:0] sreg_next;
    logic         word_complete;
    logic         drain;
    logic         load;
    logic         drop;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign sreg_next = {data_in, sreg[N-1:1]};
        end else begin : g_msb_first
            assign sreg_next = {sreg[N-2:0], data_in};
        end
    endgenerate

    // The completed word is the post-shift value, so it includes the bit sampled this edge.
    assign word_complete = bit_valid && (bit_count == LAST_BIT);
    assign drain         = (state == ST_FULL) && word_ready;
    assign load          = word_complete && ((state == ST_EMPTY) || word_ready);
    assign drop          = word_complete && (state == ST_FULL) && !word_ready;
    assign word_valid    = (state == ST_FULL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg      <= '0;
            bit_count <= '0;
            word_out  <= '0;
            state     <= ST_EMPTY;
            overrun   <= 1'b0;
        end else begin
            if (bit_valid) begin
                sreg      <= sreg_next;
                bit_count <= word_complete ? '0 : bit_count + CW'(1);
            end

            // Simultaneous drain and load keeps the buffer full with no bubble.
            if (load) begin
                word_out <= sreg_next;
                state    <= ST_FULL;
            end else if (drain) begin
                state    <= ST_EMPTY;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - self-checking bench for sipo_deser (LSB-first and MSB-first instances)
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_in0, bit_valid0, word_ready0, clear_ovr0;
    logic       data_in1, bit_valid1, word_ready1, clear_ovr1;
    logic [7:0] word_out0, word_out1;
    logic       word_valid0, word_valid1;
    logic [2:0] bit_count0, bit_count1;
    logic       overrun0, overrun1;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_w;

    always #5 clk = ~clk;

    sipo_deser #(.N(8), .LSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(reset), .data_in(data_in0), .bit_valid(bit_valid0),
        .word_out(word_out0), .word_valid(word_valid0), .word_ready(word_ready0),
        .bit_count(bit_count0), .overrun(overrun0), .clear_ovr(clear_ovr0)
    );

    sipo_deser #(.N(8), .LSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(reset), .data_in(data_in1), .bit_valid(bit_valid1),
        .word_out(word_out1), .word_valid(word_valid1), .word_ready(word_ready1),
        .bit_count(bit_count1), .overrun(overrun1), .clear_ovr(clear_ovr1)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic send_bit0(input logic b);
        data_in0 = b; bit_valid0 = 1'b1;
        @(posedge clk); @(negedge clk);
        bit_valid0 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); @(negedge clk); end
    endtask

    task automatic send_word0(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit0(w[i]);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle(2);
        if (word_out0 !== 8'h00)  begin bad++; $display("FAIL reset_word_out got=%h exp=00", word_out0); end
        total++;
        if (word_valid0 !== 1'b0) begin bad++; $display("FAIL reset_word_valid got=%b exp=0", word_valid0); end
        total++;
        if (bit_count0 !== 3'd0)  begin bad++; $display("FAIL reset_bit_count got=%0d exp=0", bit_count0); end
        total++;
        if (overrun0 !== 1'b0)    begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun0); end
        total++;
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_lsb_basic;
        logic [7:0] bits = 8'b1011_0101;
        word_ready0 = 1'b1;
        for (int i = 0; i < 8; i++) send_bit0(bits[i]);
        exp_q.push_back(8'hB5);
        if (word_valid0 !== 1'b1) begin bad++; $display("FAIL basic_valid_rise got=%b exp=1", word_valid0); end
        total++;
        exp_w = exp_q.pop_front();
        if (word_out0 !== exp_w)  begin bad++; $display("FAIL basic_word got=%h exp=%h", word_out0, exp_w); end
        total++;
        if (bit_count0 !== 3'd0)  begin bad++; $display("FAIL basic_bit_count got=%0d exp=0", bit_count0); end
        total++;
        idle(1);
        if (word_valid0 !== 1'b0) begin bad++; $display("FAIL basic_valid_one_cycle got=%b exp=0", word_valid0); end
        total++;
    endtask

    task automatic test_gaps;
        logic [7:0] bits = 8'hB5;
        word_ready0 = 1'b1;
        exp_q.push_back(8'hB5);
        for (int i = 0; i < 8; i++) begin
            send_bit0(bits[i]);
            if (i < 7) begin
                idle(1 + (i % 3));
                if (bit_count0 !== 3'(i + 1)) begin
                    bad++; $display("FAIL gap_bit_count_%0d got=%0d exp=%0d", i, bit_count0, i + 1);
                end
                total++;
            end
        end
        exp_w = exp_q.pop_front();
        if (word_valid0 !== 1'b1 || word_out0 !== exp_w) begin
            bad++; $display("FAIL gap_word got=%h/%b exp=%h/1", word_out0, word_valid0, exp_w);
        end
        total++;
        idle(1);
    endtask

    task automatic test_overrun;
        word_ready0 = 1'b0;
        send_word0(8'h3C);
        exp_q.push_back(8'h3C);
        if (overrun0 !== 1'b0) begin bad++; $display("FAIL ovr_early got=%b exp=0", overrun0); end
        total++;
        send_word0(8'hA5);
        if (word_out0 !== 8'h3C || word_valid0 !== 1'b1) begin
            bad++; $display("FAIL ovr_hold got=%h/%b exp=3c/1", word_out0, word_valid0);
        end
        total++;
        if (overrun0 !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun0); end
        total++;
        exp_w = exp_q.pop_front();
        if (word_out0 !== exp_w) begin bad++; $display("FAIL ovr_transfer_word got=%h exp=%h", word_out0, exp_w); end
        total++;
        word_ready0 = 1'b1;
        idle(1);
        word_ready0 = 1'b0;
        if (word_valid0 !== 1'b0 || word_out0 !== 8'h3C) begin
            bad++; $display("FAIL ovr_drain got=%h/%b exp=3c/0", word_out0, word_valid0);
        end
        total++;
        if (overrun0 !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun0); end
        total++;
        clear_ovr0 = 1'b1;
        idle(1);
        clear_ovr0 = 1'b0;
        if (overrun0 !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun0); end
        total++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] w2 = 8'hA5;
        word_ready0 = 1'b0;
        send_word0(8'h3C);
        exp_q.push_back(8'h3C);
        for (int i = 0; i < 7; i++) send_bit0(w2[i]);
        exp_q.push_back(8'hA5);
        exp_w = exp_q.pop_front();
        if (word_out0 !== exp_w || word_valid0 !== 1'b1) begin
            bad++; $display("FAIL b2b_first got=%h/%b exp=%h/1", word_out0, word_valid0, exp_w);
        end
        total++;
        word_ready0 = 1'b1;
        send_bit0(w2[7]);
        exp_w = exp_q.pop_front();
        if (word_out0 !== exp_w || word_valid0 !== 1'b1) begin
            bad++; $display("FAIL b2b_second got=%h/%b exp=%h/1", word_out0, word_valid0, exp_w);
        end
        total++;
        if (overrun0 !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", overrun0); end
        total++;
        idle(1);
        if (word_valid0 !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", word_valid0); end
        total++;
    endtask

    task automatic test_async_reset;
        logic [7:0] junk = 8'b0001_1111;
        word_ready0 = 1'b0;
        send_word0(8'h0F);
        send_word0(8'h0F);
        for (int i = 0; i < 5; i++) send_bit0(junk[i]);
        if (bit_count0 !== 3'd5 || overrun0 !== 1'b1 || word_valid0 !== 1'b1) begin
            bad++; $display("FAIL areset_pre got=%0d/%b/%b exp=5/1/1", bit_count0, overrun0, word_valid0);
        end
        total++;
        #2 reset = 1'b0;
        #1;
        if (word_out0 !== 8'h00 || word_valid0 !== 1'b0 || bit_count0 !== 3'd0 || overrun0 !== 1'b0) begin
            bad++; $display("FAIL areset_immediate got=%h/%b/%0d/%b exp=00/0/0/0",
                            word_out0, word_valid0, bit_count0, overrun0);
        end
        total++;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        word_ready0 = 1'b1;
        send_word0(8'h5A);
        exp_q.push_back(8'h5A);
        exp_w = exp_q.pop_front();
        if (word_out0 !== exp_w || word_valid0 !== 1'b1) begin
            bad++; $display("FAIL areset_fresh got=%h/%b exp=%h/1", word_out0, word_valid0, exp_w);
        end
        total++;
        idle(1);
    endtask

    task automatic test_msb_first;
        logic [7:0] seq = 8'b1010_1101;
        word_ready1 = 1'b1;
        exp_q.push_back(8'hB5);
        for (int i = 0; i < 8; i++) begin
            data_in1 = seq[i]; bit_valid1 = 1'b1;
            @(posedge clk); @(negedge clk);
            bit_valid1 = 1'b0;
        end
        exp_w = exp_q.pop_front();
        if (word_out1 !== exp_w || word_valid1 !== 1'b1) begin
            bad++; $display("FAIL msb_word got=%h/%b exp=%h/1", word_out1, word_valid1, exp_w);
        end
        total++;
        if (bit_count1 !== 3'd0) begin bad++; $display("FAIL msb_bit_count got=%0d exp=0", bit_count1); end
        total++;
    endtask

    initial begin
        reset = 1'b0;
        data_in0 = 1'b0; bit_valid0 = 1'b0; word_ready0 = 1'b0; clear_ovr0 = 1'b0;
        data_in1 = 1'b0; bit_valid1 = 1'b0; word_ready1 = 1'b0; clear_ovr1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_lsb_basic();
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_async_reset();
        test_msb_first();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
